// File: rtl/key_debouncer_pkg.sv
// Shared constants for the key front-end: key indices, level encoding and
// a width helper for counters sized from parameters.
package key_debouncer_pkg;

    localparam int KEY_ACTION  = 0;
    localparam int KEY_REACT   = 1;
    localparam int KEY_AVERAGE = 2;
    localparam int KEY_COMPARE = 3;

    localparam logic PRESSED  = 1'b1;
    localparam logic RELEASED = 1'b0;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Counters holding 0..value-1 need at least one bit even when value is 1.
    function automatic int cnt_width(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/key_debouncer_if.sv
// Key bundle between the raw button pins / consumer FSM (master) and the
// debouncer (slave).
interface key_debouncer_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] key_n;
  logic [NUM_KEYS-1:0] key_state;
  logic [NUM_KEYS-1:0] press_pulse;
  logic [NUM_KEYS-1:0] release_pulse;
  logic                any_press;
  logic                sample_tick;

  modport master (
    output key_n,
    input  key_state, press_pulse, release_pulse, any_press, sample_tick
  );

  modport slave (
    input  key_n,
    output key_state, press_pulse, release_pulse, any_press, sample_tick
  );
endinterface

// File: rtl/key_debounce_channel.sv
// One key: 2-flop synchroniser, tick-driven stability counter, debounced level
// and one-cycle press/release strobes registered on acceptance.
module key_debounce_channel
  import key_debouncer_pkg::*;
#(
  parameter int STABLE_SAMPLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_tick,
  input  logic key_n,
  output logic key_state,
  output logic press_pulse,
  output logic release_pulse
);
  localparam int            CW   = cnt_width(STABLE_SAMPLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_SAMPLES - 1);

  logic          sync1;
  logic          sync2;
  logic          raw_p;
  logic [CW-1:0] cnt;

  // Synchroniser resets high so an untouched key reads as released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign raw_p = ~sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      key_state     <= RELEASED;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (sample_tick) begin
        if (raw_p == key_state) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          cnt           <= '0;
          key_state     <= raw_p;
          press_pulse   <= (raw_p == PRESSED);
          release_pulse <= (raw_p == RELEASED);
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end
endmodule

// File: rtl/key_debouncer.sv
// Debounces NUM_KEYS active-low buttons: shared sample-tick prescaler feeding
// independent per-key channels; any_press is the OR of the press strobes.
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int NUM_KEYS       = 4,
  parameter int CLK_FREQ_HZ    = 12000000,
  parameter int SAMPLE_HZ      = 1000,
  parameter int STABLE_SAMPLES = 20
) (
  input logic            clk,
  input logic            rst,
  key_debouncer_if.slave bus
);
  localparam int            TICK_DIV = CLK_FREQ_HZ / SAMPLE_HZ;
  localparam int            PW       = cnt_width(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]       pre_cnt;
  logic                tick;
  logic [NUM_KEYS-1:0] state_v;
  logic [NUM_KEYS-1:0] press_v;
  logic [NUM_KEYS-1:0] release_v;

  // Tick is registered, so it lands one cycle after the count hits its top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= (pre_cnt == PRE_LAST);
      pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PW'(1);
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_channel #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .sample_tick  (tick),
      .key_n        (bus.key_n[i]),
      .key_state    (state_v[i]),
      .press_pulse  (press_v[i]),
      .release_pulse(release_v[i])
    );
  end

  assign bus.key_state     = state_v;
  assign bus.press_pulse   = press_v;
  assign bus.release_pulse = release_v;
  assign bus.any_press     = |press_v;
  assign bus.sample_tick   = tick;
endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench: per-cycle comparison against a sample-history model,
// directed scenarios with literal expectations, then randomized key activity.
module tb_key_debouncer;
  import key_debouncer_pkg::*;

  localparam int NK  = 4;
  localparam int CLK = 1000;
  localparam int SHZ = 100;
  localparam int SS  = 4;
  localparam int TD  = CLK / SHZ;
  localparam int LAT_MIN = 2 + (SS - 1) * TD;
  localparam int LAT_MAX = 2 + SS * TD;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  key_debouncer_if #(.NUM_KEYS(NK)) bus ();

  key_debouncer #(
    .NUM_KEYS      (NK),
    .CLK_FREQ_HZ   (CLK),
    .SAMPLE_HZ     (SHZ),
    .STABLE_SAMPLES(SS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a key's level flips once the last SS tick samples taken since its
  // previous flip all disagree with the current level. Samples see key_n as it
  // was two clock edges earlier; ticks occur every TD cycles after reset.
  int               n;
  logic [NK-1:0]    m_state, m_press, m_release;
  logic             m_tick;
  logic [NK-1:0]    khist[$];
  logic [NK-1:0]    ts[$];
  int               since_acc[NK];
  logic [NK-1:0]    smp;
  bit               agree;

  always @(posedge clk) begin
    if (rst) begin
      n = 0;
      m_state = '0; m_press = '0; m_release = '0; m_tick = 1'b0;
      khist.delete();
      ts.delete();
      for (int k = 0; k < NK; k++) since_acc[k] = 0;
    end else begin
      n++;
      m_press = '0;
      m_release = '0;
      if (n > 1 && (n - 1) % TD == 0) begin
        smp = (khist.size() == 2) ? khist[0] : '0;
        ts.push_back(smp);
        if (ts.size() > SS) void'(ts.pop_front());
        for (int k = 0; k < NK; k++) begin
          since_acc[k]++;
          if (since_acc[k] >= SS) begin
            agree = 1'b1;
            for (int j = 0; j < SS; j++) if (ts[j][k] == m_state[k]) agree = 1'b0;
            if (agree) begin
              m_state[k] = ~m_state[k];
              if (m_state[k]) m_press[k] = 1'b1;
              else            m_release[k] = 1'b1;
              since_acc[k] = 0;
            end
          end
        end
      end
      m_tick = (n % TD == 0);
      khist.push_back(~bus.key_n);
      if (khist.size() > 2) void'(khist.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs", {bus.key_state, bus.press_pulse, bus.release_pulse,
                            bus.any_press, bus.sample_tick}, 32'd0);
    end else begin
      chk("key_state", bus.key_state, m_state);
      chk("press_pulse", bus.press_pulse, m_press);
      chk("release_pulse", bus.release_pulse, m_release);
      chk("any_press", bus.any_press, |m_press);
      chk("sample_tick", bus.sample_tick, m_tick);
    end
  end

  int pc[NK];
  int rc[NK];
  int anyc;

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NK; k++) begin
        if (bus.press_pulse[k])   pc[k]++;
        if (bus.release_pulse[k]) rc[k]++;
      end
      if (bus.any_press) anyc++;
    end
  end

  task automatic clear_counts();
    for (int k = 0; k < NK; k++) begin
      pc[k] = 0;
      rc[k] = 0;
    end
    anyc = 0;
  endtask

  // Leaves the caller 2 time units after a rising edge, where inputs change.
  task automatic cyc(input int c);
    repeat (c) @(posedge clk);
    #2;
  endtask

  // lat = edges between the one that first sees the new input and the strobe.
  task automatic wait_strobe(input int k, input bit is_press, input int limit,
                             output int lat, output bit seen);
    lat = -1;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (is_press ? bus.press_pulse[k] : bus.release_pulse[k]) seen = 1'b1;
    end
    #1;
  endtask

  int  first_tick, tick_count, lat;
  bit  seen;
  logic [NK-1:0] cap;

  initial begin
    checks = 0;
    failures = 0;
    clear_counts();
    rst = 1'b1;
    bus.key_n = '1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;

    // Idle after reset: tick cadence and silence.
    first_tick = -1;
    tick_count = 0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (bus.sample_tick) begin
        tick_count++;
        if (first_tick < 0) first_tick = c;
      end
    end
    #1;
    chk("idle_first_tick", first_tick, 10);
    chk("idle_tick_count", tick_count, 20);
    chk("idle_presses", pc[0] + pc[1] + pc[2] + pc[3], 0);
    chk("idle_state", bus.key_state, 4'h0);

    // Clean press and release of one key.
    clear_counts();
    bus.key_n[KEY_REACT] = 1'b0;
    wait_strobe(KEY_REACT, 1'b1, 60, lat, seen);
    chk("clean_press_seen", seen, 1);
    chk("clean_press_lat_ok", (lat >= LAT_MIN && lat <= LAT_MAX), 1);
    cyc(100 - lat - 1);
    chk("clean_held_state", bus.key_state[KEY_REACT], 1);
    bus.key_n[KEY_REACT] = 1'b1;
    wait_strobe(KEY_REACT, 1'b0, 60, lat, seen);
    chk("clean_release_seen", seen, 1);
    chk("clean_release_lat_ok", (lat >= LAT_MIN && lat <= LAT_MAX), 1);
    cyc(20);
    chk("clean_press_count", pc[KEY_REACT], 1);
    chk("clean_any_count", anyc, 1);
    chk("clean_release_count", rc[KEY_REACT], 1);

    // Bounce shorter than the stability window.
    clear_counts();
    bus.key_n[KEY_ACTION] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(15);
      bus.key_n[KEY_ACTION] = ~bus.key_n[KEY_ACTION];
    end
    bus.key_n[KEY_ACTION] = 1'b1;
    cyc(60);
    chk("bounce_press_count", pc[KEY_ACTION], 0);
    chk("bounce_release_count", rc[KEY_ACTION], 0);
    chk("bounce_state", bus.key_state[KEY_ACTION], 0);

    // Two keys pressed on the same edge accept together.
    clear_counts();
    cyc($urandom_range(0, TD - 1));
    bus.key_n = 4'b1001;
    cap = '0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.any_press) begin
        seen = 1'b1;
        cap = bus.press_pulse;
      end
    end
    @(posedge clk);
    #1;
    chk("simul_seen", seen, 1);
    chk("simul_pattern", cap, 4'b0110);
    chk("simul_any_after", bus.any_press, 0);
    #1;
    cyc(20);
    chk("simul_any_count", anyc, 1);
    bus.key_n = '1;
    cyc(60);

    // Reset while a key is held: state drops, then a fresh press follows.
    clear_counts();
    bus.key_n[KEY_COMPARE] = 1'b0;
    wait_strobe(KEY_COMPARE, 1'b1, 60, lat, seen);
    chk("midrst_first_press", seen, 1);
    cyc(5);
    chk("midrst_state_before", bus.key_state[KEY_COMPARE], 1);
    rst = 1'b1;
    #1;
    chk("midrst_state_dropped", bus.key_state[KEY_COMPARE], 0);
    #1;
    cyc(2);
    rst = 1'b0;
    wait_strobe(KEY_COMPARE, 1'b1, 60, lat, seen);
    chk("midrst_repress_seen", seen, 1);
    chk("midrst_repress_lat_ok", (lat <= LAT_MAX), 1);
    cyc(20);
    chk("midrst_press_count", pc[KEY_COMPARE], 2);
    chk("midrst_release_count", rc[KEY_COMPARE], 0);
    bus.key_n[KEY_COMPARE] = 1'b1;
    cyc(60);

    // Glitch one tick before acceptance restarts the window.
    clear_counts();
    bus.key_n[KEY_AVERAGE] = 1'b0;
    cyc(3 * TD);
    bus.key_n[KEY_AVERAGE] = 1'b1;
    cyc(TD);
    chk("glitch_no_early_press", pc[KEY_AVERAGE], 0);
    bus.key_n[KEY_AVERAGE] = 1'b0;
    wait_strobe(KEY_AVERAGE, 1'b1, 60, lat, seen);
    chk("glitch_press_seen", seen, 1);
    chk("glitch_press_lat_ok", (lat >= LAT_MIN && lat <= LAT_MAX), 1);
    cyc(5);
    chk("glitch_press_count", pc[KEY_AVERAGE], 1);
    bus.key_n[KEY_AVERAGE] = 1'b1;
    cyc(60);

    // Random key activity with occasional resets, checked by the model.
    for (int it = 0; it < 120; it++) begin
      if ($urandom_range(0, 14) == 0) begin
        rst = 1'b1;
        cyc($urandom_range(1, 3));
        rst = 1'b0;
      end
      bus.key_n = bus.key_n ^ NK'($urandom);
      cyc($urandom_range(1, 70));
    end

    bus.key_n = '1;
    cyc(60);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
